// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter: parity encodings,
// FSM state encoding and the parity helper used when a word is loaded.
package uart_pkg;

    // Widest word the transmitter supports; the parity helper works on this width.
    localparam int DATA_MAX = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } par_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        BREAK  = 3'd6
    } tx_state_t;

    // Parity bit for a word zero-extended to DATA_MAX bits (extra zeros do not
    // change the XOR). Even parity makes the total count of ones even.
    function automatic logic parity_bit(input logic [DATA_MAX-1:0] data,
                                        input par_mode_t           mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register between the TX FIFO and the transmit shifter.
// Captures the word together with its per-frame configuration on accept and
// releases it when the FSM pops it into the shift register.
module uart_tx_hold
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
    input  logic              pop,
    output logic              pend_valid,
    output logic [DATA_W-1:0] pend_data,
    output par_mode_t         pend_par,
    output logic              pend_stop2
);

    logic accept;

    assign s_ready = !pend_valid;
    assign accept  = s_valid && s_ready;

    // Occupancy flag: set on accept, cleared when the FSM takes the word.
    // Accept and pop never coincide because pop needs pend_valid=1 (s_ready=0).
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend_valid <= 1'b1;
        end else if (pop) begin
            pend_valid <= 1'b0;
        end
    end

    // Payload capture; config is frozen here so later changes cannot affect this word.
    // NOTE: payload needs no reset; it is only consumed while pend_valid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_data  <= s_data;
            pend_par   <= par_mode_t'(par_mode);
            pend_stop2 <= stop2;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits (5..9) LSB first, per-frame
// parity mode and stop-bit count, paced by an external one-cycle baud_tick.
// Optional feature: define UART_TX_BREAK_EN to add brk_req/brk_active and a
// BREAK state that holds the line low for BRK_BITS ticks plus one mark tick.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BRK_BITS = 13
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              baud_tick,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [1:0]        par_mode,
    input  logic              stop2,
`ifdef UART_TX_BREAK_EN
    input  logic              brk_req,
    output logic              brk_active,
`endif
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // Elaboration-time guard on the parameter ranges.
    if (DATA_W < 5 || DATA_W > DATA_MAX || BRK_BITS < 2) begin : g_bad_param
        $error("uart_tx_cfg: DATA_W must be 5..9 and BRK_BITS at least 2");
    end

    // Holding register interface.
    logic              pend_valid;
    logic [DATA_W-1:0] pend_data;
    par_mode_t         pend_par;
    logic              pend_stop2;
    logic              pop;

    // FSM and shifter registers with their next-state values.
    tx_state_t         state_q,   state_d;
    logic              tx_q,      tx_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic              use_par_q, use_par_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q,   stop2_d;
    logic              done_q,    done_d;

    logic [DATA_MAX-1:0] par_in;
    logic                start_frame;
    logic                end_frame;

`ifdef UART_TX_BREAK_EN
    localparam int BRK_W = $clog2(BRK_BITS + 1);
    logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
    logic             brk_act_q, brk_act_d;

    assign brk_active = brk_act_q;
`endif

    uart_tx_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk        (clk),
        .areset     (areset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .par_mode   (par_mode),
        .stop2      (stop2),
        .pop        (pop),
        .pend_valid (pend_valid),
        .pend_data  (pend_data),
        .pend_par   (pend_par),
        .pend_stop2 (pend_stop2)
    );

    assign tx         = tx_q;
    assign frame_done = done_q;
    assign busy       = (state_q != IDLE) || pend_valid;

    // Zero-extend the pending word for the package parity helper.
    always_comb begin
        par_in                = '0;
        par_in[DATA_W-1:0]    = pend_data;
    end

    // Next-state logic: everything advances only on baud_tick; a frame is
    // started either from IDLE or directly at the end-of-frame tick.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        use_par_d   = use_par_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        start_frame = 1'b0;
        end_frame   = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_cnt_d   = brk_cnt_q;
        brk_act_d   = brk_act_q;
`endif

        if (baud_tick) begin
            case (state_q)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (brk_req) begin
                        state_d   = BREAK;
                        tx_d      = 1'b0;
                        brk_cnt_d = '0;
                        brk_act_d = 1'b1;
                    end else if (pend_valid) begin
                        start_frame = 1'b1;
                    end
`else
                    if (pend_valid) begin
                        start_frame = 1'b1;
                    end
`endif
                end
                START: begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = CNT_W'(1);
                end
                DATA: begin
                    if (bit_cnt_q == CNT_W'(DATA_W)) begin
                        if (use_par_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP1;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    state_d = STOP1;
                    tx_d    = 1'b1;
                end
                STOP1: begin
                    if (stop2_q) begin
                        state_d = STOP2;
                        tx_d    = 1'b1;
                    end else begin
                        end_frame = 1'b1;
                    end
                end
                STOP2: begin
                    end_frame = 1'b1;
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    // Low for BRK_BITS ticks, then one mark tick; brk_req is not
                    // looked at again so releasing it cannot shorten the break.
                    if (brk_cnt_q == BRK_W'(BRK_BITS)) begin
                        if (pend_valid) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        if (brk_cnt_q == BRK_W'(BRK_BITS - 1)) begin
                            tx_d      = 1'b1;
                            brk_act_d = 1'b0;
                        end
                        brk_cnt_d = brk_cnt_q + BRK_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Last stop bit finished: pulse frame_done and chain the next word if any.
        if (end_frame) begin
            done_d = 1'b1;
            if (pend_valid) begin
                start_frame = 1'b1;
            end else begin
                state_d   = IDLE;
                tx_d      = 1'b1;
                bit_cnt_d = '0;
            end
        end

        // Move the held word and its configuration into the shifter.
        if (start_frame) begin
            state_d   = START;
            tx_d      = 1'b0;
            bit_cnt_d = '0;
            shift_d   = pend_data;
            use_par_d = (pend_par != PAR_NONE);
            par_bit_d = parity_bit(par_in, pend_par);
            stop2_d   = pend_stop2;
            pop       = 1'b1;
        end
    end

    // State and datapath registers; reset drives the line idle-high at once.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            use_par_q <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt_q <= '0;
            brk_act_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            use_par_q <= use_par_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            done_q    <= done_d;
`ifdef UART_TX_BREAK_EN
            brk_cnt_q <= brk_cnt_d;
            brk_act_q <= brk_act_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (DATA_W=8). Ticks are issued
// one at a time; tx is sampled on the falling edge right after each tick edge.
// The break scenario is built only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       areset;
    logic       baud_tick;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [1:0] par_mode;
    logic       stop2;
    logic       brk_req;
    logic       brk_active;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    uart_tx_cfg #(
        .DATA_W   (8),
        .BRK_BITS (13)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .baud_tick  (baud_tick),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .par_mode   (par_mode),
        .stop2      (stop2),
`ifdef UART_TX_BREAK_EN
        .brk_req    (brk_req),
        .brk_active (brk_active),
`endif
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

`ifndef UART_TX_BREAK_EN
    assign brk_active = 1'b0;
`endif

    always #5 clk = ~clk;

    // Count frame_done pulses independently of the stimulus process.
    always @(posedge clk) begin
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // One baud tick: high for exactly one clk edge; returns at the falling edge after it.
    task automatic do_tick();
        @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
    endtask

    // Issue n ticks and collect tx after each, first tick in the highest used bit.
    task automatic run_ticks(input int n, output logic [31:0] seq);
        seq = '0;
        for (int i = 0; i < n; i++) begin
            do_tick();
            seq = {seq[30:0], tx};
            repeat (2) @(negedge clk);
        end
    endtask

    // Present one word for a single accept edge, waiting (bounded) for s_ready.
    task automatic send_word(input logic [7:0] d, input logic [1:0] pm, input logic s2);
        int waited = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (s_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_wait: s_ready=%b after %0d cycles, required 1", s_ready, waited);
        end
        s_valid  = 1'b1;
        s_data   = d;
        par_mode = pm;
        stop2    = s2;
        @(negedge clk);
        s_valid  = 1'b0;
        s_data   = 8'hC3;
    endtask

    task automatic test_reset();
        areset    = 1'b0;
        baud_tick = 1'b0;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        par_mode  = 2'b00;
        stop2     = 1'b0;
        brk_req   = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (tx !== 1'b1)         begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (s_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        // Ticks while idle with nothing pending leave the line high.
        begin
            logic [31:0] seq;
            run_ticks(3, seq);
            n_cmp++; if (seq[2:0] !== 3'b111) begin n_bad++; $display("FAIL idle_ticks: got %b want 111", seq[2:0]); end
        end
    endtask

    // 0x23 with even, odd and no parity, one stop bit each.
    task automatic test_parity();
        logic [1:0]  modes [3] = '{2'b01, 2'b10, 2'b00};
        int          lens  [3] = '{11, 11, 10};
        logic [31:0] exps  [3] = '{32'b01100010011, 32'b01100010001, 32'b0110001001};
        logic [31:0] seq;
        logic [31:0] mask;
        int          d0;
        for (int k = 0; k < 3; k++) begin
            send_word(8'h23, modes[k], 1'b0);
            n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL par%0d_s_ready: got %b want 0", k, s_ready); end
            n_cmp++; if (busy !== 1'b1)    begin n_bad++; $display("FAIL par%0d_busy: got %b want 1", k, busy); end
            d0 = done_cnt;
            run_ticks(lens[k], seq);
            mask = (32'd1 << lens[k]) - 32'd1;
            n_cmp++; if ((seq & mask) !== exps[k]) begin n_bad++; $display("FAIL par%0d_frame: got %b want %b", k, seq & mask, exps[k]); end
            n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL par%0d_early_done: got %0d pulses want 0", k, done_cnt - d0); end
            run_ticks(1, seq);
            n_cmp++; if (seq[0] !== 1'b1) begin n_bad++; $display("FAIL par%0d_eof_tx: got %b want 1", k, seq[0]); end
            n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL par%0d_done: got %0d pulses want 1", k, done_cnt - d0); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL par%0d_idle_busy: got %b want 0", k, busy); end
        end
    endtask

    // 0x55 then 0xAA, no parity, two stops; second word accepted mid-frame.
    task automatic test_back_to_back();
        logic [31:0] seq;
        logic        first;
        int          d0;
        d0 = done_cnt;
        send_word(8'h55, 2'b00, 1'b1);
        run_ticks(1, seq);
        first = seq[0];
        send_word(8'hAA, 2'b00, 1'b1);
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_s_ready: got %b want 0", s_ready); end
        run_ticks(21, seq);
        n_cmp++; if ({first, seq[20:0]} !== 22'b01010101011_00101010111) begin
            n_bad++; $display("FAIL b2b_frames: got %b want %b", {first, seq[20:0]}, 22'b01010101011_00101010111);
        end
        run_ticks(1, seq);
        n_cmp++; if (seq[0] !== 1'b1) begin n_bad++; $display("FAIL b2b_eof_tx: got %b want 1", seq[0]); end
        n_cmp++; if (done_cnt !== d0 + 2) begin n_bad++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt - d0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b want 0", busy); end
    endtask

    // Accept on the same edge as a tick; config changed after accept must not matter.
    task automatic test_tick_coincident();
        logic [31:0] seq;
        int          d0;
        d0 = done_cnt;
        @(negedge clk);
        s_valid   = 1'b1;
        s_data    = 8'h0F;
        par_mode  = 2'b00;
        stop2     = 1'b0;
        baud_tick = 1'b1;
        @(negedge clk);
        s_valid   = 1'b0;
        baud_tick = 1'b0;
        par_mode  = 2'b11;
        stop2     = 1'b1;
        n_cmp++; if (tx !== 1'b1)      begin n_bad++; $display("FAIL coin_tx: got %b want 1", tx); end
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL coin_s_ready: got %b want 0", s_ready); end
        n_cmp++; if (busy !== 1'b1)    begin n_bad++; $display("FAIL coin_busy: got %b want 1", busy); end
        repeat (2) @(negedge clk);
        run_ticks(1, seq);
        n_cmp++; if (seq[0] !== 1'b0)  begin n_bad++; $display("FAIL coin_start: got %b want 0", seq[0]); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL coin_popped: got %b want 1", s_ready); end
        run_ticks(9, seq);
        n_cmp++; if (seq[8:0] !== 9'b111100001) begin n_bad++; $display("FAIL coin_frame: got %b want 111100001", seq[8:0]); end
        run_ticks(1, seq);
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL coin_done: got %0d pulses want 1", done_cnt - d0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL coin_busy_end: got %b want 0", busy); end
        par_mode = 2'b00;
        stop2    = 1'b0;
    endtask

    // Reset during data bit 4 of 0x33 with 0x0F pending: nothing is sent afterwards.
    task automatic test_reset_mid_frame();
        logic [31:0] seq;
        int          d0;
        send_word(8'h33, 2'b00, 1'b0);
        run_ticks(6, seq);
        n_cmp++; if (seq[5:0] !== 6'b011001) begin n_bad++; $display("FAIL rst_pre_frame: got %b want 011001", seq[5:0]); end
        send_word(8'h0F, 2'b00, 1'b0);
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_pending: got %b want 0", s_ready); end
        @(negedge clk);
        #2 areset = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1)      begin n_bad++; $display("FAIL rst_async_tx: got %b want 1", tx); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_async_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        @(negedge clk);
        areset = 1'b1;
        d0 = done_cnt;
        run_ticks(14, seq);
        n_cmp++; if (seq[13:0] !== 14'h3FFF) begin n_bad++; $display("FAIL rst_no_frame: got %b want all ones", seq[13:0]); end
        n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - d0); end
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rst_busy_after: got %b want 0", busy); end
    endtask

`ifdef UART_TX_BREAK_EN
    // Break requested in IDLE with 0x70 pending: 13 low ticks, one mark, then the frame.
    task automatic test_break();
        logic [31:0] seq;
        logic [12:0] low_seq;
        logic [12:0] act_seq;
        int          d0;
        d0      = done_cnt;
        brk_req = 1'b1;
        send_word(8'h70, 2'b00, 1'b0);
        for (int i = 0; i < 13; i++) begin
            do_tick();
            low_seq = {low_seq[11:0], tx};
            act_seq = {act_seq[11:0], brk_active};
            brk_req = 1'b0;
            repeat (2) @(negedge clk);
        end
        n_cmp++; if (low_seq !== 13'h0000) begin n_bad++; $display("FAIL brk_low: got %b want all zeros", low_seq); end
        n_cmp++; if (act_seq !== 13'h1FFF) begin n_bad++; $display("FAIL brk_active: got %b want all ones", act_seq); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL brk_busy: got %b want 1", busy); end
        run_ticks(1, seq);
        n_cmp++; if (seq[0] !== 1'b1) begin n_bad++; $display("FAIL brk_mark: got %b want 1", seq[0]); end
        n_cmp++; if (brk_active !== 1'b0) begin n_bad++; $display("FAIL brk_mark_active: got %b want 0", brk_active); end
        run_ticks(10, seq);
        n_cmp++; if (seq[9:0] !== 10'b0000011101) begin n_bad++; $display("FAIL brk_frame: got %b want 0000011101", seq[9:0]); end
        run_ticks(1, seq);
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL brk_done: got %0d pulses want 1", done_cnt - d0); end
    endtask
`endif

    initial begin
        test_reset();
        test_parity();
        test_back_to_back();
        test_tick_coincident();
        test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8-bit UART transmitter, sitting between the TX FIFO and the serial line.
- Data width is a parameter; parity mode and stop-bit count are selected per frame.
- Bit timing comes from the existing baud generator's one-cycle tick.
- A one-entry holding register gives gapless back-to-back frames.
- Frames are sent LSB first.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
BRK_BITS, 13, break length in baud ticks (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
areset  in  1  asynchronous active-low reset.
baud_tick  in  1  one-clk pulse per bit period, from the baud generator.
s_valid  in  1  FIFO has a word to send.
s_ready  out  1  block can accept a word; equals !pend_valid.
s_data  in  DATA_W  word to send.
par_mode  in  2  parity select, sampled at accept: 00 none, 01 even, 10 odd, 11 mark (always 1).
stop2  in  1  sampled at accept: 1 = two stop bits, 0 = one.
tx  out  1  serial line; idle high; registered.
busy  out  1  (state != IDLE) || pend_valid.
frame_done  out  1  one-clk pulse at the end of the last stop bit.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - tx=1, s_ready=1, busy=0, frame_done=0.
  - state=IDLE, pend_valid=0, bit_cnt=0.
  - Asserting reset mid-frame forces tx=1 immediately and discards both the pending word and the in-flight word.
- Accept:
  - On a clk edge with s_valid && s_ready, latch s_data, par_mode and stop2 into the holding register and set pend_valid.
  - s_ready drops the next cycle.
- States, all advancing only on clk edges where baud_tick=1:
  - IDLE: if pend_valid, go to START, set tx=0, move the holding register into the shift register and config registers, and clear pend_valid.
  - START: go to DATA; tx=bit0; bit_cnt=1.
  - DATA: tx=next bit, bit_cnt++. After bit DATA_W-1 has been driven for one tick, go to PARITY if par_mode!=00, else STOP1.
  - PARITY: tx is the parity bit. Even = XOR of data; odd = its complement; mark = 1. Then go to STOP1.
  - STOP1: tx=1. Then go to STOP2 if stop2 latched, else end-of-frame.
  - STOP2: tx=1. Then end-of-frame.
  - End-of-frame tick:
    - frame_done=1 for that clk only.
    - If pend_valid, go straight to START with tx=0 (zero idle bits between frames).
    - Otherwise go to IDLE with tx=1.
- Bit period: each bit occupies exactly one baud_tick interval. Frame length = 1 + DATA_W + (par?1:0) + (stop2?2:1) ticks.
- Latency: a word accepted while IDLE starts its start bit at the first baud_tick strictly after the accept edge.
- Accept coinciding with baud_tick:
  - The tick sees the old pend_valid=0, so no start on that tick; the start bit comes on the next tick.
  - Accepting during a frame never disturbs it.
- Configuration changes: changes to par_mode or stop2 after accept have no effect on that word.
- baud_tick while IDLE with no pending word: no effect.
- s_valid while s_ready=0: ignored; s_data need not be held.

Optional Feature:
UART_TX_BREAK_EN
- With the macro defined:
  - Adds input brk_req and output brk_active; adds state BREAK.
  - At a tick in IDLE with brk_req=1, break has priority over pend_valid. The block enters BREAK with tx=0 and brk_active=1.
  - It stays there for BRK_BITS ticks, then drives tx=1 for one mark tick and returns to IDLE. Any pending word is then sent normally.
  - brk_req deasserted mid-break does not shorten the break.
  - busy=1 throughout.
- Without the macro: the ports and state are absent, and behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE/PAR_EVEN/PAR_ODD/PAR_MARK;
  - the state typedef/localparams IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK;
  - a parity function of DATA_W bits.
- One natural sub-module, uart_tx_hold: the one-entry holding register (valid/ready, data, config). The FSM and shifter stay in uart_tx_cfg.

Test Plan:
- DATA_W=8, s_data=0x23, par_mode=01, stop2=0 -> tx per tick: 0,1,1,0,0,0,1,0,0,1,1; frame_done pulses once after 11 ticks.
- Same word with par_mode=10 -> parity bit 0; with par_mode=00 -> 10-tick frame with no parity bit.
- Back-to-back 0x55 then 0xAA, par_mode=00, stop2=1, second word accepted during the first frame -> the second start bit immediately follows the first frame's STOP2 tick. That gives 22 contiguous ticks, two frame_done pulses, and no idle high bit between frames.
- Accept on the same clk edge as baud_tick -> tx stays 1 on that tick and the start bit appears on the next tick; s_ready=0 from the cycle after accept until the word moves to the shifter.
- Reset asserted at data bit 4 of 0x33 with a word pending -> tx=1 asynchronously, s_ready=1, busy=0; after release, no further frame is sent.
- UART_TX_BREAK_EN defined, brk_req pulsed in IDLE with 0x70 pending -> tx=0 for 13 ticks with brk_active=1, then one mark tick, then frame 0x70.
